mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Initiator for the data memory: accepts one load/store request at a time from the datapath and issues the word accesses the memory understands (write enable, word address, write data, read data).
- Handles byte, halfword and word sizes: lane extraction and sign/zero extension for loads, read-modify-write for sub-word stores.
- Flags misaligned or out-of-range accesses without touching memory.

Parameters:
- MEM_WORDS, 257: memory depth in 32-bit words (word indices 0..256).
- AW, 32: byte-address width of the request and memory address buses.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  AW  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  one-cycle pulse: transaction complete.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  valid with resp_valid: misaligned, illegal size or out of range.
- mem_ewr  output  1  memory write enable.
- mem_dir  output  AW  memory word index (req_addr >> 2).
- mem_din  output  32  memory write data.
- mem_dout  input  32  memory read data, combinational from mem_dir.

Behaviour:
- Clocking: single clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, req_ready 0 while rst is high, mem_ewr 0, mem_dir 0, mem_din 0, resp_valid 0, resp_rdata 0, resp_err 0.
- States: IDLE, READ, RMW_RD, RMW_WR, WRITE, RESP.
- IDLE: req_ready = 1. A handshake (req_valid && req_ready at an edge) latches the request and registers mem_dir = req_addr[AW-1:2].
- Error check at accept. Error if any of:
  - req_size = 11;
  - size half and addr[0] = 1;
  - size word and addr[1:0] != 0;
  - word index >= MEM_WORDS.
  On error: go to RESP with resp_err = 1. mem_ewr is never asserted. Latency 1 cycle.
- Load: IDLE -> READ (mem_ewr = 0). At the end of READ, capture mem_dout and extract lane addr[1:0] (little-endian: byte lane n = bits [8n+7:8n]; half lane = addr[1]). Extend per req_unsigned, then go to RESP. Latency 2 cycles.
- Word store: IDLE -> WRITE. mem_din = req_wdata, mem_ewr = 1 for exactly one cycle, then RESP. Latency 2 cycles.
- Byte/half store: IDLE -> RMW_RD (capture mem_dout) -> RMW_WR. In RMW_WR, mem_din = captured word with the target lane(s) replaced and mem_ewr = 1 for one cycle, then RESP. Latency 3 cycles.
- RESP: resp_valid = 1 for one cycle, then IDLE. The response is not back-pressured. req_ready = 0 in every non-IDLE state, so a new request can be accepted in the cycle after RESP at the earliest.
- Memory bus stability:
  - mem_dir and mem_din are registered and held constant for the whole transaction.
  - mem_ewr is decoded from registered state only, so no glitches; it falls at the edge that leaves WRITE/RMW_WR.
  - Outside WRITE/RMW_WR, mem_ewr is 0.
- resp_rdata and resp_err hold their values until the next RESP. resp_rdata = 0 for stores and errors.
- Reset mid-transaction: at the edge sampling rst = 1, the controller returns to IDLE and mem_ewr drops. No response is issued for the aborted request. A write already presented in WRITE/RMW_WR is not rolled back.
- req_* inputs are ignored outside the IDLE handshake.

Decomposition:
- Package mem_ctrl_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state enumeration;
  - MEM_WORDS default.
- Sub-module lane_align (combinational): given word, addr[1:0], size and unsigned flag, produces the extended load value. Given old word and new data, produces the merged store word.

Test Plan:
- Word store 0xDEADBEEF at addr 0x10 -> mem_dir = 4, mem_ewr high exactly one cycle, resp_valid at handshake+2 with resp_err = 0. Then word load from 0x10 -> resp_rdata = 0xDEADBEEF at handshake+2.
- Byte store 0xAA at addr 0x11 over word 0x11223344 -> RMW_RD, then RMW_WR writes 0x1122AA44, resp at handshake+3. Signed byte load from 0x11 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
- Half load from 0x12 over 0x8001_7FFF: signed -> 0xFFFF8001; unsigned -> 0x00008001. Half store 0x1234 at 0x12 -> word becomes 0x1234_7FFF.
- Misaligned word load at 0x0A, half store at 0x03, size 11, and addr 0x404 (index 257) -> resp_err = 1 at handshake+1, mem_ewr never asserted, memory unchanged.
- Back-to-back: req_valid held high with two queued requests -> req_ready low from the cycle after the handshake through RESP. Second handshake no earlier than the cycle after resp_valid; exactly one resp_valid pulse per request.
- Assert rst during RMW_RD of a byte store -> next cycle IDLE, req_ready = 1 after rst is released, mem_ewr = 0, no resp_valid, target word unchanged.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the data-memory controller: size codes, FSM states and the latched request.
package mem_ctrl_pkg;

    localparam int unsigned MEM_WORDS_DEF = 257;
    localparam int unsigned DW            = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RMW_RD,
        RMW_WR,
        WRITE,
        RESP
    } state_e;

    // Request fields still needed after the handshake
    typedef struct packed {
        size_e           size;
        logic            uns;
        logic [1:0]      off;
        logic [DW-1:0]   wdata;
    } req_t;

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering: extended load value and merged store word for a given offset and size.
module lane_align
    import mem_ctrl_pkg::*;
(
    input  logic [DW-1:0] word,
    input  logic [1:0]    off,
    input  size_e         size,
    input  logic          uns,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] load_c,
    output logic [DW-1:0] merge_c
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v  = word[{off, 3'b000} +: 8];
        half_v  = word[{off[1], 4'b0000} +: 16];
        load_c  = word;
        merge_c = word;
        case (size)
            SZ_BYTE: begin
                load_c = {{24{byte_v[7] & ~uns}}, byte_v};
                merge_c[{off, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_c = {{16{half_v[15] & ~uns}}, half_v};
                merge_c[{off[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_c  = word;
                merge_c = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Load/store initiator for a word-wide data memory with sub-word read-modify-write.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
    parameter int unsigned AW        = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic          mem_ewr,
    output logic [AW-1:0] mem_dir,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam int unsigned IW = AW - 2;

    state_e          state, state_next;
    req_t            req_q;
    logic            accept_c;
    logic            err_c;
    logic [IW-1:0]   idx_c;
    logic [DW-1:0]   load_c;
    logic [DW-1:0]   merge_c;

    assign idx_c = req_addr[AW-1:2];

    // Alignment, size and range check on the incoming request
    always_comb begin
        err_c = 1'b0;
        case (size_e'(req_size))
            SZ_ILL:  err_c = 1'b1;
            SZ_HALF: err_c = req_addr[0];
            SZ_WORD: err_c = |req_addr[1:0];
            default: err_c = 1'b0;
        endcase
        if (idx_c >= IW'(MEM_WORDS)) begin
            err_c = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept_c = 1'b1;
                    if (err_c) begin
                        state_next = RESP;
                    end else if (!req_we) begin
                        state_next = READ;
                    end else if (size_e'(req_size) == SZ_WORD) begin
                        state_next = WRITE;
                    end else begin
                        state_next = RMW_RD;
                    end
                end
            end
            READ:    state_next = RESP;
            RMW_RD:  state_next = RMW_WR;
            RMW_WR:  state_next = RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so the memory bus never glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            mem_ewr    <= 1'b0;
            mem_dir    <= '0;
            mem_din    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            req_q      <= '0;
        end else begin
            state      <= state_next;
            req_ready  <= (state_next == IDLE);
            mem_ewr    <= (state_next == WRITE) || (state_next == RMW_WR);
            resp_valid <= (state_next == RESP);
            if (accept_c) begin
                req_q.size  <= size_e'(req_size);
                req_q.uns   <= req_unsigned;
                req_q.off   <= req_addr[1:0];
                req_q.wdata <= req_wdata;
                mem_dir     <= AW'(idx_c);
                if (req_we && !err_c && (size_e'(req_size) == SZ_WORD)) begin
                    mem_din <= req_wdata;
                end
            end
            if (state == RMW_RD) begin
                mem_din <= merge_c;
            end
            if (state_next == RESP) begin
                resp_err   <= (state == IDLE);
                resp_rdata <= (state == READ) ? load_c : '0;
            end
        end
    end

    lane_align u_lane_align (
        .word    (mem_dout),
        .off     (req_q.off),
        .size    (req_q.size),
        .uns     (req_q.uns),
        .wdata   (req_q.wdata),
        .load_c  (load_c),
        .merge_c (merge_c)
    );

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: reference model on an array, monitor pops expectations on resp_valid.
`timescale 1ns/1ps
module tb_mem_ctrl;

    localparam int unsigned NW = 257;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_init;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_ewr;
    logic [31:0] mem_dir, mem_din, mem_dout;

    logic [31:0] mem     [NW];
    logic [31:0] ref_mem [NW];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          hs;
        int          lat;
        int          nwr;
        logic [31:0] idx;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   ewr_cnt     = 0;
    int   last_resp   = -1;

    always #5 clk = ~clk;

    mem_ctrl #(.MEM_WORDS(NW), .AW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_ewr      (mem_ewr),
        .mem_dir      (mem_dir),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout)
    );

    function automatic logic [31:0] pattern(input int i);
        return 32'(i) * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    // Memory the controller talks to
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < NW; i++) mem[i] <= pattern(i);
        end else if (mem_ewr && mem_dir < 32'(NW)) begin
            mem[mem_dir[8:0]] <= mem_din;
        end
    end
    assign mem_dout = (mem_dir < 32'(NW)) ? mem[mem_dir[8:0]] : 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference behaviour: byte-addressed memory with little-endian lanes
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
        logic [31:0] idx, w, v, mask;
        int sh;
        idx     = addr >> 2;
        sh      = 8 * int'(addr[1:0]);
        e.idx   = idx;
        e.rdata = 32'h0;
        e.nwr   = 0;
        e.hs    = 0;
        e.err   = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                  (size == 2'b10 && addr[1:0] != 2'b00) || (idx >= 32'(NW));
        if (e.err) begin
            e.lat = 1;
        end else if (!we) begin
            e.lat = 2;
            w = ref_mem[idx[8:0]];
            if (size == 2'b00) begin
                v = (w >> sh) & 32'hFF;
                if (!uns && v >= 32'h80) v = v - 32'd256;
            end else if (size == 2'b01) begin
                v = (w >> sh) & 32'hFFFF;
                if (!uns && v >= 32'h8000) v = v - 32'd65536;
            end else begin
                v = w;
            end
            e.rdata = v;
        end else if (size == 2'b10) begin
            e.lat = 2;
            e.nwr = 1;
            ref_mem[idx[8:0]] = wdata;
        end else begin
            e.lat = 3;
            e.nwr = 1;
            w    = ref_mem[idx[8:0]];
            mask = ((size == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
            ref_mem[idx[8:0]] = (w & ~mask) | ((wdata << sh) & mask);
        end
    endtask

    // Monitor: pops one expectation per response pulse
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            ewr_cnt = 0;
        end else begin
            if (mem_ewr) begin
                ewr_cnt++;
                if (q.size() > 0) check("mem_dir_on_write", mem_dir, q[0].idx);
                else check("write_without_request", 32'(mem_ewr), 32'h0);
            end
            if (q.size() > 0) check("req_ready_busy", 32'(req_ready), 32'h0);
            if (resp_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_resp", 32'(resp_valid), 32'h0);
                end else begin
                    mon_e = q.pop_front();
                    check("resp_rdata", resp_rdata, mon_e.rdata);
                    check("resp_err", 32'(resp_err), 32'(mon_e.err));
                    check("resp_latency", 32'(cyc - mon_e.hs), 32'(mon_e.lat));
                    check("write_pulses", 32'(ewr_cnt), 32'(mon_e.nwr));
                    last_resp = cyc;
                end
                ewr_cnt = 0;
            end
        end
    end

    // Call just after a rising edge; returns just after the handshake edge
    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit keep, input bit abort);
        exp_t e;
        int   t;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        t = 0;
        while (t < 50) begin
            @(negedge clk);
            if (req_ready) break;
            t++;
        end
        if (t >= 50) begin
            check("handshake_timeout", 32'(req_ready), 32'h1);
            req_valid = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        @(posedge clk);
        check("handshake_after_resp", 32'(cyc > last_resp), 32'h1);
        if (!abort) begin
            model(we, size, uns, addr, wdata, e);
            e.hs = cyc;
            q.push_back(e);
        end
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d outstanding", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1; mem_init = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < NW; i++) ref_mem[i] = pattern(i);
        repeat (3) @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_mem_ewr", 32'(mem_ewr), 32'h0);
        check("rst_mem_dir", mem_dir, 32'h0);
        check("rst_mem_din", mem_din, 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;

        // Word store/load
        send(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0);
        send(0, 2'b10, 0, 32'h10, 32'h0, 0, 0);
        // Byte RMW and byte loads
        send(1, 2'b10, 0, 32'h10, 32'h11223344, 0, 0);
        send(1, 2'b00, 0, 32'h11, 32'h5555_55AA, 0, 0);
        send(0, 2'b10, 0, 32'h10, 32'h0, 0, 0);
        send(0, 2'b00, 0, 32'h11, 32'h0, 0, 0);
        send(0, 2'b00, 1, 32'h11, 32'h0, 0, 0);
        // Half loads and half RMW
        send(1, 2'b10, 0, 32'h10, 32'h80017FFF, 0, 0);
        send(0, 2'b01, 0, 32'h12, 32'h0, 0, 0);
        send(0, 2'b01, 1, 32'h12, 32'h0, 0, 0);
        send(1, 2'b01, 0, 32'h12, 32'hABCD1234, 0, 0);
        send(0, 2'b10, 0, 32'h10, 32'h0, 0, 0);
        // Error cases
        send(0, 2'b10, 0, 32'h0A, 32'h0, 0, 0);
        send(1, 2'b01, 0, 32'h03, 32'hFFFF, 0, 0);
        send(1, 2'b11, 0, 32'h20, 32'h1234, 0, 0);
        send(0, 2'b10, 0, 32'h404, 32'h0, 0, 0);
        send(1, 2'b10, 0, 32'h404, 32'hCAFEF00D, 0, 0);
        send(1, 2'b00, 0, 32'h400, 32'h77, 0, 0);
        // Back-to-back with req_valid held high
        send(1, 2'b00, 0, 32'h21, 32'h5A, 1, 0);
        send(0, 2'b10, 0, 32'h20, 32'h0, 1, 0);
        send(0, 2'b01, 0, 32'h22, 32'h0, 0, 0);

        // Reset during RMW_RD of a byte store
        send(1, 2'b10, 0, 32'h10, 32'h11223344, 0, 0);
        send(1, 2'b00, 0, 32'h11, 32'hAA, 0, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_mem_ewr", 32'(mem_ewr), 32'h0);
        check("abort_resp_valid", 32'(resp_valid), 32'h0);
        check("abort_req_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_ready_after", 32'(req_ready), 32'h1);
        check("abort_word_intact", mem[4], 32'h11223344);
        @(posedge clk);
        #1;
        send(0, 2'b10, 0, 32'h10, 32'h0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'($urandom_range(0, 32'h40F));
            send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 a, 32'($urandom), (n != 299) && ($urandom_range(0, 3) == 0), 0);
        end
        req_valid = 1'b0;

        t = 0;
        while (q.size() > 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("responses_outstanding", 32'(q.size()), 32'h0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < NW; i++) check($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
